// File: rtl/alarm_sequencer.sv
// Alarm system central sequencer: key edge detection, exit/entry delay timing,
// tripped-zone latching and the registered 8-bit LED status word.
module alarm_sequencer #(
  parameter int EXIT_TICKS  = 100,
  parameter int ENTRY_TICKS = 50,
  parameter int STROBE_HALF = 2
) (
  input  logic       CLK_100ms,
  input  logic       SYS_RST,
  input  logic       panic_key,
  input  logic       arm_key,
  input  logic [2:0] zone_sensor,
  output logic [7:0] LED,
  output logic [2:0] state
);

  localparam int TMAX = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = (STROBE_HALF > 1) ? $clog2(STROBE_HALF) : 1;

  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_EXIT_DLY  = 3'd1,
    S_ARMED     = 3'd2,
    S_ENTRY_DLY = 3'd3,
    S_ALARM     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            strobe_q, strobe_d;
  logic [2:0]      zone_q, zone_d;
  logic            panic_q, arm_q;
  logic [7:0]      led_q, led_d;

  logic panic_rise, arm_rise, changed, blinking, latching;

  assign panic_rise = panic_key & ~panic_q;
  assign arm_rise   = arm_key & ~arm_q;

  always_ff @(posedge CLK_100ms or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q  <= S_DISARMED;
      timer_q  <= '0;
      scnt_q   <= '0;
      strobe_q <= 1'b0;
      zone_q   <= '0;
      panic_q  <= 1'b0;
      arm_q    <= 1'b0;
      led_q    <= 8'h80;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      scnt_q   <= scnt_d;
      strobe_q <= strobe_d;
      zone_q   <= zone_d;
      panic_q  <= panic_key;
      arm_q    <= arm_key;
      led_q    <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISARMED:  if (arm_rise) state_d = S_EXIT_DLY;
      S_EXIT_DLY: begin
        if (arm_rise)                              state_d = S_DISARMED;
        else if (timer_q == TW'(EXIT_TICKS - 1))   state_d = S_ARMED;
      end
      S_ARMED: begin
        if (arm_rise)                state_d = S_DISARMED;
        else if (|zone_sensor[2:1])  state_d = S_ALARM;
        else if (zone_sensor[0])     state_d = S_ENTRY_DLY;
      end
      S_ENTRY_DLY: begin
        if (arm_rise)                              state_d = S_DISARMED;
        else if (|zone_sensor[2:1])                state_d = S_ALARM;
        else if (timer_q == TW'(ENTRY_TICKS - 1))  state_d = S_ALARM;
      end
      S_ALARM:     if (arm_rise) state_d = S_DISARMED;
      default:     state_d = S_DISARMED;
    endcase
    // Panic overrides everything, but an illegal code still recovers to DISARMED.
    if (panic_rise && (state_q == S_DISARMED || state_q == S_EXIT_DLY ||
        state_q == S_ARMED || state_q == S_ENTRY_DLY || state_q == S_ALARM))
      state_d = S_ALARM;

    changed  = (state_d != state_q);
    blinking = (state_q == S_EXIT_DLY) || (state_q == S_ENTRY_DLY) || (state_q == S_ALARM);
    latching = (state_q == S_ARMED) || (state_q == S_ENTRY_DLY) || (state_q == S_ALARM);

    if (changed)                 timer_d = '0;
    else if (timer_q == '1)      timer_d = timer_q;
    else                         timer_d = timer_q + 1'b1;

    strobe_d = strobe_q;
    scnt_d   = scnt_q + 1'b1;
    if (changed || !blinking) begin
      strobe_d = 1'b0;
      scnt_d   = '0;
    end else if (scnt_q == SW'(STROBE_HALF - 1)) begin
      strobe_d = ~strobe_q;
      scnt_d   = '0;
    end

    zone_d = zone_q;
    if (state_d == S_DISARMED || state_d == S_EXIT_DLY) zone_d = '0;
    else if (latching)                                  zone_d = zone_q | zone_sensor;
  end

  // LED is built from next-state values so it moves on the same edge as state.
  always_comb begin
    case (state_d)
      S_DISARMED:  led_d = {1'b1, 2'b00, zone_sensor, 2'b00};
      S_EXIT_DLY:  led_d = {1'b0, strobe_d, 6'b000000};
      S_ARMED:     led_d = {2'b01, 1'b0, zone_d, 2'b00};
      S_ENTRY_DLY: led_d = {1'b0, strobe_d, 1'b0, zone_d, 2'b00};
      S_ALARM:     led_d = {2'b01, 1'b0, zone_d, strobe_d, 1'b1};
      default:     led_d = 8'h80;
    endcase
  end

  assign LED   = led_q;
  assign state = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: delays, zone latching, strobe, key priority, reset.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       panic_key, arm_key;
  logic [2:0] zone_sensor;
  logic [7:0] LED;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alarm_sequencer #(.EXIT_TICKS(100), .ENTRY_TICKS(50), .STROBE_HALF(2)) dut (
    .CLK_100ms  (clk),
    .SYS_RST    (rst),
    .panic_key  (panic_key),
    .arm_key    (arm_key),
    .zone_sensor(zone_sensor),
    .LED        (LED),
    .state      (state)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From DISARMED with arm released: pulse arm and wait out the exit delay.
  task automatic go_armed();
    arm_key = 1'b1;
    tick();
    chk("arm_exit", {5'd0, state}, 8'd1);
    arm_key = 1'b0;
    repeat (99) tick();
    chk("exit_99", {5'd0, state}, 8'd1);
    tick();
    chk("exit_100", {5'd0, state}, 8'd2);
  endtask

  initial begin
    rst = 1'b1;
    panic_key = 1'b0;
    arm_key = 1'b0;
    zone_sensor = 3'b000;
    repeat (2) tick();
    chk("rst_led", LED, 8'h80);
    chk("rst_state", {5'd0, state}, 8'd0);
    rst = 1'b0;

    // T1: live sensor view while disarmed
    zone_sensor = 3'b010;
    tick();
    chk("t1_led", LED, 8'h88);
    chk("t1_state", {5'd0, state}, 8'd0);
    zone_sensor = 3'b000;
    tick();
    chk("t1_led_clr", LED, 8'h80);

    // T2: exit delay, strobe on LED6, sensors ignored
    arm_key = 1'b1;
    tick();
    chk("t2_state", {5'd0, state}, 8'd1);
    chk("t2_led0", LED, 8'h00);
    arm_key = 1'b0;
    tick(); chk("t2_led1", LED, 8'h00);
    tick(); chk("t2_led2", LED, 8'h40);
    tick(); chk("t2_led3", LED, 8'h40);
    tick(); chk("t2_led4", LED, 8'h00);
    for (int i = 5; i <= 99; i++) begin
      zone_sensor = (i < 50) ? 3'b111 : 3'b000;
      tick();
      chk("t2_hold", {5'd0, state}, 8'd1);
    end
    tick();
    chk("t2_armed", {5'd0, state}, 8'd2);
    chk("t2_armed_led", LED, 8'h40);

    // T3: entry zone -> entry delay -> alarm
    zone_sensor = 3'b001;
    tick();
    chk("t3_entry", {5'd0, state}, 8'd3);
    chk("t3_led0", LED, 8'h04);
    zone_sensor = 3'b000;
    tick(); chk("t3_led1", LED, 8'h04);
    tick(); chk("t3_led2", LED, 8'h44);
    tick(); chk("t3_led3", LED, 8'h44);
    tick(); chk("t3_led4", LED, 8'h04);
    repeat (45) tick();
    chk("t3_entry49", {5'd0, state}, 8'd3);
    tick();
    chk("t3_alarm", {5'd0, state}, 8'd4);
    chk("t3_alarm_led", LED, 8'h45);
    tick(); chk("t3_strb1", LED, 8'h45);
    tick(); chk("t3_strb2", LED, 8'h47);
    tick(); chk("t3_strb3", LED, 8'h47);
    tick(); chk("t3_strb4", LED, 8'h45);

    // Disarm from alarm, re-arm
    arm_key = 1'b1;
    tick();
    chk("disarm", {5'd0, state}, 8'd0);
    chk("disarm_led", LED, 8'h80);
    arm_key = 1'b0;
    tick();
    go_armed();

    // T4: instant zone trips alarm on the same edge
    zone_sensor = 3'b100;
    tick();
    chk("t4_state", {5'd0, state}, 8'd4);
    chk("t4_led", LED, 8'h51);
    zone_sensor = 3'b000;
    arm_key = 1'b1;
    tick();
    chk("t4_disarm", LED, 8'h80);
    arm_key = 1'b0;
    tick();

    // T5: panic beats arm; held keys do not retrigger
    panic_key = 1'b1;
    arm_key = 1'b1;
    tick();
    chk("t5_state", {5'd0, state}, 8'd4);
    chk("t5_led", LED, 8'h41);
    tick();
    chk("t5_hold1", LED, 8'h41);
    tick();
    chk("t5_hold2", LED, 8'h43);
    chk("t5_hold_state", {5'd0, state}, 8'd4);
    panic_key = 1'b0;
    arm_key = 1'b0;
    tick();
    arm_key = 1'b1;
    tick();
    chk("t5_disarm", {5'd0, state}, 8'd0);
    arm_key = 1'b0;
    tick();

    // T6: asynchronous reset during entry delay
    go_armed();
    zone_sensor = 3'b001;
    tick();
    chk("t6_entry", {5'd0, state}, 8'd3);
    zone_sensor = 3'b000;
    repeat (30) tick();
    #10 rst = 1'b1;
    #1;
    chk("t6_async_led", LED, 8'h80);
    chk("t6_async_state", {5'd0, state}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_led", LED, 8'h80);
    chk("t6_post_state", {5'd0, state}, 8'd0);
    go_armed();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
